// File: rtl/loop_counter_unit.sv
// loop_counter_unit: tile-loop counters (i rows, j cols, h inner) with bound registers and
// a configuration legality check. Define LOOP_CNT_OVF_CHK_EN to trap counter overruns.
module loop_counter_unit #(
    parameter int DIM_W     = 16,
    parameter int TILE_LOG2 = 2,
    parameter int DIM_MAX   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIM_W-1:0]           cfg_m,
    input  logic [DIM_W-1:0]           cfg_n,
    input  logic [DIM_W-1:0]           cfg_k,
    input  logic                       M_en,
    input  logic                       N_en,
    input  logic                       K_en,
    input  logic                       err_cal,
    output logic                       err_found,
    input  logic                       i_cnt,
    input  logic                       j_cnt,
    input  logic                       h_cnt,
    input  logic                       i_rstn,
    input  logic                       j_rstn,
    input  logic                       h_rstn,
    output logic                       i_max,
    output logic                       j_max,
    output logic                       h_max,
    output logic                       h_in_point,
    output logic                       h_out_point,
    output logic [DIM_W-TILE_LOG2:0]   i_idx,
    output logic [DIM_W-TILE_LOG2:0]   j_idx,
    output logic [DIM_W-TILE_LOG2:0]   h_idx,
    output logic                       ovf_err
);

    localparam int IW = DIM_W - TILE_LOG2 + 1;
    localparam int CW = DIM_W + 1;

    // Ceiling division by the tile edge; the extra bit keeps the rounding carry.
    function automatic logic [IW-1:0] tile_count(input logic [DIM_W-1:0] dim);
        logic [CW-1:0] sum;
        sum = {1'b0, dim} + CW'((1 << TILE_LOG2) - 1);
        return IW'(sum >> TILE_LOG2);
    endfunction

    function automatic logic dim_illegal(input logic [DIM_W-1:0] dim);
        return (dim == {DIM_W{1'b0}}) || ({1'b0, dim} > CW'(DIM_MAX));
    endfunction

    // Clear beats increment beats hold; behaviour at the terminal value depends on the build.
    function automatic logic [IW-1:0] cnt_next(
        input logic [IW-1:0] cur,
        input logic [IW-1:0] term,
        input logic          clr_n,
        input logic          inc
    );
        logic [IW-1:0] nxt;
        if (!clr_n) begin
            nxt = {IW{1'b0}};
        end else if (inc) begin
            if (cur == term) begin
`ifdef LOOP_CNT_OVF_CHK_EN
                nxt = cur;
`else
                nxt = {IW{1'b0}};
`endif
            end else begin
                nxt = cur + IW'(1'b1);
            end
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [IW-1:0] mt_r;
    logic [IW-1:0] nt_r;
    logic [IW-1:0] kt_r;
    logic [IW-1:0] i_idx_r;
    logic [IW-1:0] j_idx_r;
    logic [IW-1:0] h_idx_r;
    logic [IW-1:0] i_idx_s;
    logic [IW-1:0] j_idx_s;
    logic [IW-1:0] h_idx_s;
    logic [IW-1:0] h_term_s;
    logic          cfg_bad_s;
    logic          err_found_r;

    // Next counter values, inner-loop terminal bound and raw legality of the cfg inputs
    always_comb begin
        h_term_s  = kt_r + IW'(1'b1);
        i_idx_s   = cnt_next(i_idx_r, mt_r, i_rstn, i_cnt);
        j_idx_s   = cnt_next(j_idx_r, nt_r, j_rstn, j_cnt);
        h_idx_s   = cnt_next(h_idx_r, h_term_s, h_rstn, h_cnt);
        cfg_bad_s = dim_illegal(cfg_m) | dim_illegal(cfg_n) | dim_illegal(cfg_k);
    end

    // Tile-count bound registers; reloading does not disturb the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_r <= {IW{1'b0}};
            nt_r <= {IW{1'b0}};
            kt_r <= {IW{1'b0}};
        end else begin
            if (M_en) begin
                mt_r <= tile_count(cfg_m);
            end
            if (N_en) begin
                nt_r <= tile_count(cfg_n);
            end
            if (K_en) begin
                kt_r <= tile_count(cfg_k);
            end
        end
    end

    // Loop counters, all updated independently on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx_r <= {IW{1'b0}};
            j_idx_r <= {IW{1'b0}};
            h_idx_r <= {IW{1'b0}};
        end else begin
            i_idx_r <= i_idx_s;
            j_idx_r <= j_idx_s;
            h_idx_r <= h_idx_s;
        end
    end

    // Legality flag: sampled from the live cfg inputs so it is valid right after setup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_found_r <= 1'b0;
        end else if (err_cal) begin
            err_found_r <= cfg_bad_s;
        end else begin
            err_found_r <= err_found_r;
        end
    end

`ifdef LOOP_CNT_OVF_CHK_EN
    logic ovf_hit_s;
    logic ovf_err_r;

    // An increment request at the terminal value is an overrun (a clear takes priority)
    always_comb begin
        ovf_hit_s = (i_rstn & i_cnt & (i_idx_r == mt_r))
                  | (j_rstn & j_cnt & (j_idx_r == nt_r))
                  | (h_rstn & h_cnt & (h_idx_r == h_term_s));
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_r <= 1'b0;
        end else begin
            ovf_err_r <= ovf_err_r | ovf_hit_s;
        end
    end

    assign ovf_err = ovf_err_r;
`else
    assign ovf_err = 1'b0;
`endif

    assign err_found   = err_found_r;
    assign i_idx       = i_idx_r;
    assign j_idx       = j_idx_r;
    assign h_idx       = h_idx_r;
    assign i_max       = (i_idx_r == mt_r);
    assign j_max       = (j_idx_r == nt_r);
    assign h_max       = (h_idx_r == h_term_s);
    assign h_in_point  = (h_idx_r < kt_r);
    assign h_out_point = (h_idx_r == kt_r);

endmodule

// File: tb/tb_loop_counter_unit.sv
// Self-checking bench for loop_counter_unit: directed scenarios followed by randomized
// stimulus checked against an integer reference model of the loop rules.
module tb_loop_counter_unit;

    localparam int DIM_W     = 16;
    localparam int TILE_LOG2 = 2;
    localparam int DIM_MAX   = 1024;
    localparam int IW        = DIM_W - TILE_LOG2 + 1;
    localparam int TILE      = 1 << TILE_LOG2;
    localparam int LIM       = 1 << IW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIM_W-1:0] cfg_m, cfg_n, cfg_k;
    logic             M_en, N_en, K_en, err_cal;
    logic             i_cnt, j_cnt, h_cnt, i_rstn, j_rstn, h_rstn;
    logic             err_found, i_max, j_max, h_max, h_in_point, h_out_point, ovf_err;
    logic [IW-1:0]    i_idx, j_idx, h_idx;

    int checks = 0;
    int errors = 0;

    // reference model state
    int mt, nt, kt, mi, mj, mh;
    bit merr, movf;
    bit ovf_mode;

    loop_counter_unit #(.DIM_W(DIM_W), .TILE_LOG2(TILE_LOG2), .DIM_MAX(DIM_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .M_en(M_en), .N_en(N_en), .K_en(K_en),
        .err_cal(err_cal), .err_found(err_found),
        .i_cnt(i_cnt), .j_cnt(j_cnt), .h_cnt(h_cnt),
        .i_rstn(i_rstn), .j_rstn(j_rstn), .h_rstn(h_rstn),
        .i_max(i_max), .j_max(j_max), .h_max(h_max),
        .h_in_point(h_in_point), .h_out_point(h_out_point),
        .i_idx(i_idx), .j_idx(j_idx), .h_idx(h_idx),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mt = 0; nt = 0; kt = 0; mi = 0; mj = 0; mh = 0; merr = 1'b0; movf = 1'b0;
    endtask

    task automatic ctr_rule(input int cur, input int term, input logic clr_n, input logic inc,
                            output int nxt, output bit hit);
        hit = 1'b0;
        nxt = cur;
        if (!clr_n) nxt = 0;
        else if (inc) begin
            if (cur == term) begin
                hit = 1'b1;
                nxt = ovf_mode ? cur : 0;
            end else nxt = (cur + 1) % LIM;
        end
    endtask

    function automatic bit bad_dim(input int d);
        return (d == 0) || (d > DIM_MAX);
    endfunction

    // Apply the loop rules for one rising edge, using the bounds held before the edge.
    task automatic model_edge();
        int ni, nj, nh;
        bit hi, hj, hh;
        ctr_rule(mi, mt, i_rstn, i_cnt, ni, hi);
        ctr_rule(mj, nt, j_rstn, j_cnt, nj, hj);
        ctr_rule(mh, kt + 1, h_rstn, h_cnt, nh, hh);
        if (ovf_mode && (hi || hj || hh)) movf = 1'b1;
        mi = ni; mj = nj; mh = nh;
        if (M_en) mt = (int'(cfg_m) + TILE - 1) / TILE;
        if (N_en) nt = (int'(cfg_n) + TILE - 1) / TILE;
        if (K_en) kt = (int'(cfg_k) + TILE - 1) / TILE;
        if (err_cal) merr = bad_dim(int'(cfg_m)) || bad_dim(int'(cfg_n)) || bad_dim(int'(cfg_k));
    endtask

    task automatic compare_all(input string ctx);
        check_val({ctx, "_i_idx"}, 32'(i_idx), mi);
        check_val({ctx, "_j_idx"}, 32'(j_idx), mj);
        check_val({ctx, "_h_idx"}, 32'(h_idx), mh);
        check_val({ctx, "_i_max"}, 32'(i_max), 32'(mi == mt));
        check_val({ctx, "_j_max"}, 32'(j_max), 32'(mj == nt));
        check_val({ctx, "_h_max"}, 32'(h_max), 32'(mh == kt + 1));
        check_val({ctx, "_h_in"}, 32'(h_in_point), 32'(mh < kt));
        check_val({ctx, "_h_out"}, 32'(h_out_point), 32'(mh == kt));
        check_val({ctx, "_err"}, 32'(err_found), 32'(merr));
        check_val({ctx, "_ovf"}, 32'(ovf_err), 32'(movf));
    endtask

    task automatic idle_inputs();
        M_en = 1'b0; N_en = 1'b0; K_en = 1'b0; err_cal = 1'b0;
        i_cnt = 1'b0; j_cnt = 1'b0; h_cnt = 1'b0;
        i_rstn = 1'b1; j_rstn = 1'b1; h_rstn = 1'b1;
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ctx);
        idle_inputs();
    endtask

    function automatic logic [DIM_W-1:0] rand_dim();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return '0;
        if (sel == 1) return DIM_W'(DIM_MAX + $urandom_range(1, 3));
        if (sel == 2) return DIM_W'(DIM_MAX);
        return DIM_W'($urandom_range(1, 24));
    endfunction

    initial begin
`ifdef LOOP_CNT_OVF_CHK_EN
        ovf_mode = 1'b1;
`else
        ovf_mode = 1'b0;
`endif
        idle_inputs();
        cfg_m = '0; cfg_n = '0; cfg_k = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check_val("reset_h_out", 32'(h_out_point), 32'd1);
        check_val("reset_i_max", 32'(i_max), 32'd1);
        #2 rst_n = 1'b1;
        step("idle0");

        // setup with a legal configuration
        cfg_m = 16'd8; cfg_n = 16'd4; cfg_k = 16'd12;
        M_en = 1'b1; N_en = 1'b1; K_en = 1'b1; err_cal = 1'b1;
        step("setup");
        check_val("setup_err", 32'(err_found), 32'd0);

        // inner loop walk with kt=3
        h_rstn = 1'b0;
        step("h_clr");
        for (int s = 0; s < 4; s++) begin
            h_cnt = 1'b1;
            step("h_walk");
        end
        check_val("h_walk_max", 32'(h_max), 32'd1);
        check_val("h_walk_idx", 32'(h_idx), 32'd4);

        // row loop with cfg_m=5 -> mt=2, then overrun and clear-beats-increment
        cfg_m = 16'd5; M_en = 1'b1; i_rstn = 1'b0;
        step("m5");
        i_cnt = 1'b1; step("i_inc1");
        i_cnt = 1'b1; step("i_inc2");
        check_val("i_full_max", 32'(i_max), 32'd1);
        i_cnt = 1'b1; step("i_over");
        check_val("i_over_idx", 32'(i_idx), ovf_mode ? 32'd2 : 32'd0);
        check_val("i_over_ovf", 32'(ovf_err), ovf_mode ? 32'd1 : 32'd0);
        i_cnt = 1'b1; step("i_again");
        i_rstn = 1'b0; i_cnt = 1'b1;
        step("i_clr_pri");
        check_val("i_clr_pri_idx", 32'(i_idx), 32'd0);

        // error flag sticky until the next evaluation
        cfg_k = 16'd0; err_cal = 1'b1;
        step("k0");
        check_val("k0_err", 32'(err_found), 32'd1);
        cfg_k = 16'd4;
        step("k0_hold");
        check_val("k0_hold_err", 32'(err_found), 32'd1);
        err_cal = 1'b1;
        step("k4");
        check_val("k4_err", 32'(err_found), 32'd0);
        cfg_k = 16'd0; err_cal = 1'b1;
        step("k0b");

        // asynchronous reset mid-loop
        j_rstn = 1'b0; h_rstn = 1'b0; step("pre_clr");
        j_cnt = 1'b1; h_cnt = 1'b1; step("pre1");
        h_cnt = 1'b1; step("pre2");
        check_val("pre_h", 32'(h_idx), 32'd2);
        check_val("pre_j", 32'(j_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_i", 32'(i_idx), 32'd0);
        check_val("async_j", 32'(j_idx), 32'd0);
        check_val("async_h", 32'(h_idx), 32'd0);
        check_val("async_err", 32'(err_found), 32'd0);
        compare_all("async");
        #2 rst_n = 1'b1;
        step("post_rst");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_m = rand_dim(); cfg_n = rand_dim(); cfg_k = rand_dim();
            M_en    = ($urandom_range(0, 7) == 0);
            N_en    = ($urandom_range(0, 7) == 0);
            K_en    = ($urandom_range(0, 7) == 0);
            err_cal = ($urandom_range(0, 3) == 0);
            i_cnt   = ($urandom_range(0, 1) == 0);
            j_cnt   = ($urandom_range(0, 1) == 0);
            h_cnt   = ($urandom_range(0, 1) == 0);
            i_rstn  = ($urandom_range(0, 9) != 0);
            j_rstn  = ($urandom_range(0, 9) != 0);
            h_rstn  = ($urandom_range(0, 9) != 0);
            step("rand");
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare_all("rand_rst");
                #2 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_counter_unit.md
LOOP_COUNTER_UNIT -- requirements
Module: loop_counter_unit

Interface
REQ-001 Parameter DIM_W, default 16: width of each matrix dimension input.
REQ-002 Parameter TILE_LOG2, default 2: log2 of the systolic tile edge (4x4 array).
REQ-003 Parameter DIM_MAX, default 1024: largest legal value of M, N or K.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Ports cfg_m, cfg_n, cfg_k  in  DIM_W: matrix dimensions, output rows, output cols, inner dim.
REQ-007 Ports M_en, N_en, K_en  in  1: load the matching cfg_* and its tile count.
REQ-008 Port err_cal  in  1: evaluate a dimension legality check on cfg_* this cycle.
REQ-009 Port err_found  out  1: registered illegal-configuration flag.
REQ-010 Ports i_cnt, j_cnt, h_cnt  in  1: increment the matching loop counter by one.
REQ-011 Ports i_rstn, j_rstn, h_rstn  in  1: active-low synchronous clear of the matching counter.
REQ-012 Ports i_max, j_max, h_max  out  1: loop-exhausted flags, combinational from registers.
REQ-013 Ports h_in_point, h_out_point  out  1: inner-loop phase flags, combinational from registers.
REQ-014 Ports i_idx, j_idx, h_idx  out  DIM_W-TILE_LOG2+1: current counter values for address generation.
REQ-015 Port ovf_err  out  1: sticky counter-overrun flag (see Configuration).

Function
REQ-016 Tile counts: mt=ceil(cfg_m/2^TILE_LOG2), nt=ceil(cfg_n/...), kt=ceil(cfg_k/...), computed in DIM_W+1 bits so that no carry is lost, and registered on the edge where the matching *_en is 1.
REQ-017 i counts row tiles 0..mt; i_max=1 iff i_idx==mt.
REQ-018 j counts column tiles 0..nt; j_max=1 iff j_idx==nt.
REQ-019 h counts inner steps 0..kt+1; h_max=1 iff h_idx==kt+1.
REQ-020 h_in_point=1 iff h_idx<kt: an input tile still needs loading.
REQ-021 h_out_point=1 iff h_idx==kt: the accumulated output tile is ready for writeback.
REQ-022 Per counter, priority is rstn low (clear to 0), then cnt high (increment by 1), then hold; the updated value is visible the cycle after the edge.
REQ-023 Counters are independent; simultaneous i_cnt/j_cnt/h_cnt all take effect on the same edge.
REQ-024 On the edge where err_cal=1: err_found <= (cfg_m==0)|(cfg_n==0)|(cfg_k==0)|(any cfg_*>DIM_MAX); the check reads the cfg_* inputs directly, not the registered copies, so that the result is valid in the cycle after SETUP.
REQ-025 err_found holds its value until the next err_cal or reset.
REQ-026 A *_en while counters are non-zero reloads the bounds; counters are not cleared, and the max flags re-evaluate against the new bounds in the next cycle.

Reset
REQ-027 While rst_n=0: all counters=0, mt/nt/kt=0, err_found=0, ovf_err=0.
REQ-028 Immediately after reset, with bounds 0: i_max=j_max=1, h_max=0, h_in_point=0, h_out_point=1.
REQ-029 Reset asserted mid-loop clears all state immediately, with no dependency on clk.

Configuration
REQ-030 Macro LOOP_CNT_OVF_CHK_EN defined: a cnt pulse while its counter is already at its terminal value (mt, nt or kt+1) does not change the counter and sets ovf_err=1, which stays set until reset.
REQ-031 Macro LOOP_CNT_OVF_CHK_EN undefined: such a cnt pulse wraps the counter to 0, and ovf_err is tied to 0.

Verification
REQ-032 cfg_m=8, cfg_n=4, cfg_k=12, all *_en=1 and err_cal=1 for one cycle -> next cycle: err_found=0, mt=2, nt=1, kt=3.
REQ-033 cfg_k=0 with err_cal=1 -> err_found=1 next cycle; err_found stays 1 until a later err_cal with cfg_k=4.
REQ-034 kt=3: h_rstn=0 then four h_cnt pulses -> h_idx=0,1,2 give h_in_point=1; h_idx=3 gives h_out_point=1; h_idx=4 gives h_max=1.
REQ-035 cfg_m=5 -> mt=2; two i_cnt pulses -> i_max=1; i_rstn=0 and i_cnt=1 on the same edge -> i_idx=0.
REQ-036 mt=2 with i_idx=2, extra i_cnt pulse -> with the macro: i_idx stays 2 and ovf_err=1; without the macro: i_idx=0 and ovf_err=0.
REQ-037 Drive rst_n low asynchronously while h_idx=2 and j_idx=1 -> all idx=0 and err_found=0 before the next clk edge.
